// File: rtl/mem_responder_if.sv
// Request/response channel between a fetch/LSU initiator and mem_responder.
// The initiator uses the master modport, the memory uses the slave modport.
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [ADDR_WIDTH-1:0]     req_addr_i;
    logic                      req_wen_i;
    logic [DATA_WIDTH/8-1:0]   req_wstrb_i;
    logic [DATA_WIDTH-1:0]     req_wdata_i;
    logic                      resp_valid_o;
    logic                      resp_ready_i;
    logic [DATA_WIDTH-1:0]     resp_rdata_o;
    logic                      resp_err_o;

    modport master (
        output req_valid_i, req_addr_i, req_wen_i,
        output req_wstrb_i, req_wdata_i, resp_ready_i,
        input  req_ready_o, resp_valid_o,
        input  resp_rdata_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_wen_i,
        input  req_wstrb_i, req_wdata_i, resp_ready_i,
        output req_ready_o, resp_valid_o,
        output resp_rdata_o, resp_err_o
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word RAM behind a valid/ready request/response channel.
// One request in flight; the access happens on the edge entering RESP.
module mem_responder #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h80000000,
    parameter int                    LATENCY     = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    mem_responder_if.slave bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wen_q;
    logic [NB-1:0]           wstrb_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH_WORDS];

    logic                    idle;
    logic                    enter_resp;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic                    acc_wen;
    logic [NB-1:0]           acc_wstrb;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic [ADDR_WIDTH-1:0]   acc_off;
    logic [IDX_W-1:0]        acc_idx;
    logic                    acc_err;
    logic [DATA_WIDTH-1:0]   acc_rdata;
    logic                    mem_we;

    assign idle = (state_q == IDLE);

    // With LATENCY=1 the access uses the request as it is handed over.
    always_comb begin
        acc_addr  = addr_q;
        acc_wen   = wen_q;
        acc_wstrb = wstrb_q;
        acc_wdata = wdata_q;
        if (idle) begin
            acc_addr  = bus.req_addr_i;
            acc_wen   = bus.req_wen_i;
            acc_wstrb = bus.req_wstrb_i;
            acc_wdata = bus.req_wdata_i;
        end
    end

    always_comb begin
        acc_off   = acc_addr - BASE_ADDR;
        acc_idx   = IDX_W'(acc_off >> 2);
        acc_err   = (acc_addr < BASE_ADDR)
                  || ({1'b0, acc_off} >= SPAN)
                  || (acc_addr[1:0] != 2'b00);
        acc_rdata = '0;
        if (!acc_wen && !acc_err) begin
            acc_rdata = mem_q[acc_idx];
        end
    end

    always_comb begin
        enter_resp = 1'b0;
        if (idle && bus.req_valid_i && LATENCY == 1) begin
            enter_resp = 1'b1;
        end
        if (state_q == WAIT && cnt_q == 4'd1) begin
            enter_resp = 1'b1;
        end
    end

    assign mem_we = enter_resp && acc_wen && !acc_err;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (acc_wstrb[b]) begin
                    mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        addr_q  <= bus.req_addr_i;
                        wen_q   <= bus.req_wen_i;
                        wstrb_q <= bus.req_wstrb_i;
                        wdata_q <= bus.req_wdata_i;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= enter_resp ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (enter_resp) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (enter_resp) begin
                rdata_q <= acc_rdata;
                err_q   <= acc_err;
            end
        end
    end

    assign bus.req_ready_o  = idle;
    assign bus.resp_valid_o = (state_q == RESP);
    assign bus.resp_rdata_o = rdata_q;
    assign bus.resp_err_o   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder at LATENCY 2, 4 and 1.
// Expected responses are queued at request time and popped on handshake.
module tb_mem_responder;
    localparam int ND = 3;
    localparam int LATS [ND] = '{2, 4, 1};
    localparam logic [31:0] BASE = 32'h80000000;

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [ND-1:0]        rst_n;
    logic [ND-1:0]        req_valid;
    logic [ND-1:0]        req_ready;
    logic [ND-1:0][31:0]  req_addr;
    logic [ND-1:0]        req_wen;
    logic [ND-1:0][3:0]   req_wstrb;
    logic [ND-1:0][31:0]  req_wdata;
    logic [ND-1:0]        resp_valid;
    logic [ND-1:0]        resp_ready;
    logic [ND-1:0][31:0]  resp_rdata;
    logic [ND-1:0]        resp_err;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        mem_responder_if u_if ();
        assign u_if.req_valid_i  = req_valid[g];
        assign u_if.req_addr_i   = req_addr[g];
        assign u_if.req_wen_i    = req_wen[g];
        assign u_if.req_wstrb_i  = req_wstrb[g];
        assign u_if.req_wdata_i  = req_wdata[g];
        assign u_if.resp_ready_i = resp_ready[g];
        assign req_ready[g]      = u_if.req_ready_o;
        assign resp_valid[g]     = u_if.resp_valid_o;
        assign resp_rdata[g]     = u_if.resp_rdata_o;
        assign resp_err[g]       = u_if.resp_err_o;
        mem_responder #(
            .LATENCY(LATS[g])
        ) u_dut (
            .clk_i (clk),
            .rst_ni(rst_n[g]),
            .bus   (u_if.slave)
        );
    end

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb [$];
    exp_t mon_e;
    int   acc_cyc [ND];
    bit   seen [ND];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (req_valid[d] && req_ready[d]) acc_cyc[d] = cyc + 1;
            if (resp_valid[d] && !seen[d]) begin
                seen[d] = 1'b1;
                chk("latency", 32'(cyc + 1 - acc_cyc[d]), 32'(LATS[d]));
            end
            if (resp_valid[d] && resp_ready[d]) begin
                seen[d] = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(d), 32'hFFFFFFFF);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_dut", 32'(d), 32'(mon_e.dut));
                    chk("rdata", resp_rdata[d], mon_e.rdata);
                    chk("err", 32'(resp_err[d]), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic send(input int d, input logic wen,
                        input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input logic [31:0] er,
                        input logic ee, input bit push, output int acc);
        bit ok = 1'b0;
        acc          = 0;
        req_addr[d]  = addr;
        req_wen[d]   = wen;
        req_wstrb[d] = strb;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        if (push) sb.push_back('{d, er, ee});
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready[d]) begin
                ok  = 1'b1;
                acc = cyc + 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          a;
        int          prev;
        logic [31:0] hold;
        logic [31:0] v;
        rst_n      = '0;
        req_valid  = '0;
        req_addr   = '0;
        req_wen    = '0;
        req_wstrb  = '0;
        req_wdata  = '0;
        resp_ready = '1;
        for (int d = 0; d < ND; d++) begin
            acc_cyc[d] = 0;
            seen[d]    = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready[0]), 32'd1);
        chk("rst_valid", 32'(resp_valid[0]), 32'd0);
        chk("rst_rdata", resp_rdata[0], 32'd0);
        chk("rst_err", 32'(resp_err[0]), 32'd0);
        rst_n = '1;
        @(posedge clk);
        #1;

        // LATENCY=2: basic read, partial write, errors, boundary
        send(0, 1, BASE,       4'hF, 32'hDEADBEEF, 0, 0, 1, a);
        send(0, 1, BASE + 4,   4'hF, 32'hAAAAAAAA, 0, 0, 1, a);
        send(0, 0, BASE,       4'h0, 0, 32'hDEADBEEF, 0, 1, a);
        send(0, 1, BASE + 4,   4'h5, 32'h11223344, 0, 0, 1, a);
        send(0, 0, BASE + 4,   4'h0, 0, 32'hAA22AA44, 0, 1, a);
        send(0, 0, 32'h7FFFFFFC, 4'h0, 0, 0, 1, 1, a);
        send(0, 0, BASE + 32'h1000, 4'h0, 0, 0, 1, 1, a);
        send(0, 1, BASE + 2,   4'hF, 32'h12345678, 0, 1, 1, a);
        send(0, 0, BASE,       4'h0, 0, 32'hDEADBEEF, 0, 1, a);
        send(0, 1, BASE + 32'hFFC, 4'hF, 32'h0BADF00D, 0, 0, 1, a);
        send(0, 0, BASE + 32'hFFC, 4'h0, 0, 32'h0BADF00D, 0, 1, a);
        drain();

        // backpressure with a competing request presented
        resp_ready[0] = 1'b0;
        send(0, 0, BASE, 4'h0, 0, 32'hDEADBEEF, 0, 1, a);
        for (int i = 0; i < 20; i++) begin
            if (resp_valid[0]) break;
            @(negedge clk);
        end
        hold = 32'hDEADBEEF;
        req_addr[0]  = BASE + 4;
        req_wen[0]   = 1'b0;
        req_valid[0] = 1'b1;
        sb.push_back('{0, 32'hAA22AA44, 1'b0});
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(resp_valid[0]), 32'd1);
            chk("bp_rdata", resp_rdata[0], hold);
            chk("bp_ready", 32'(req_ready[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        resp_ready[0] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready_after", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        drain();

        // LATENCY=4: reset drops an in-flight write
        send(1, 1, BASE + 16, 4'hF, 32'h55667788, 0, 0, 1, a);
        send(1, 0, BASE + 16, 4'h0, 0, 32'h55667788, 0, 1, a);
        drain();
        send(1, 1, BASE + 16, 4'hF, 32'hFFFFFFFF, 0, 0, 0, a);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n[1] = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready[1]), 32'd1);
        chk("mid_rst_valid", 32'(resp_valid[1]), 32'd0);
        chk("mid_rst_rdata", resp_rdata[1], 32'd0);
        chk("mid_rst_err", 32'(resp_err[1]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n[1] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        send(1, 0, BASE + 16, 4'h0, 0, 32'h55667788, 0, 1, a);
        drain();

        // LATENCY=1: back-to-back read sweep
        for (int i = 0; i < 8; i++) begin
            v = 32'hA5A5A5A5 ^ (32'(i) * 32'h01010101);
            send(2, 1, BASE + 32'(4 * i), 4'hF, v, 0, 0, 1, a);
        end
        drain();
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            v = 32'hA5A5A5A5 ^ (32'(i) * 32'h01010101);
            send(2, 0, BASE + 32'(4 * i), 4'h0, 0, v, 0, 1, a);
            if (i > 0) chk("sweep_period", 32'(a - prev), 32'd2);
            prev = a;
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the core's load/store and fetch traffic: accepts one request at a time over a valid/ready request channel, services it from an internal word-addressed RAM after a fixed latency, and returns read data or a write acknowledgement over a valid/ready response channel. It replaces the zero-latency combinational memory model, so that fetch and LSU initiators can be exercised against realistic multi-cycle memory.

## Interface
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, data width; byte strobes are DATA_WIDTH/8 bits
- DEPTH_WORDS, 1024, RAM depth in words
- BASE_ADDR, 32'h80000000, byte address of word 0
- LATENCY, 2, cycles from request handshake to resp_valid_o; legal range 1..15
- clk_i  input  1  clock, all state on rising edge
- rst_ni  input  1  asynchronous, active-low reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request ready
- req_addr_i  input  ADDR_WIDTH  byte address
- req_wen_i  input  1  1 = write, 0 = read
- req_wstrb_i  input  DATA_WIDTH/8  byte write enables (ignored for reads)
- req_wdata_i  input  DATA_WIDTH  write data
- resp_valid_o  output  1  response valid
- resp_ready_i  input  1  response ready
- resp_rdata_o  output  DATA_WIDTH  read data; 0 for writes and errors
- resp_err_o  output  1  access error

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready_o=1. Handshake (req_valid_i & req_ready_o) latches addr/wen/wstrb/wdata and loads counter with LATENCY-1. If LATENCY-1=0 go to RESP, else go to WAIT.
- WAIT: req_ready_o=0; counter decrements each cycle. On the edge where counter is 1, go to RESP.
- On the edge entering RESP, perform the access:
  - read: resp_rdata_o <= RAM[idx]
  - write: bytes with strobe=1 are updated; resp_rdata_o <= 0
- idx = (addr - BASE_ADDR) >> 2, computed with an ADDR_WIDTH-bit subtraction.
- Error when addr < BASE_ADDR, addr >= BASE_ADDR + 4*DEPTH_WORDS, or addr[1:0] != 0. On error: no RAM write, resp_rdata_o=0, resp_err_o=1.
- RESP: resp_valid_o=1; resp_rdata_o and resp_err_o are held stable until the handshake (resp_valid_o & resp_ready_i). On the handshake, return to IDLE.
- Requests are accepted only in IDLE; the block never holds more than one request in flight.
- RAM contents are not reset. The bench preloads them by hierarchical access or $readmemh.

## Timing
- Reset (rst_ni=0, takes effect immediately): state=IDLE, req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, counter=0.
- Reset mid-operation drops the in-flight request. A write is committed only if the transition into RESP occurred before reset asserted.
- Request handshake at edge T gives resp_valid_o=1 from edge T+LATENCY.
- Back-to-back throughput: a response handshake at edge R raises req_ready_o after R; the next request can be accepted at edge R+1. Minimum period is LATENCY+1 cycles per request.
- Read-after-write to the same word returns the updated data.
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.

## Test plan
- Preload RAM[0]=32'hDEADBEEF. Read 0x80000000 with LATENCY=2, accepted at edge T → resp_valid_o at T+2, rdata=32'hDEADBEEF, err=0.
- Partial write: write 0x80000004, wdata=32'h11223344, wstrb=4'b0101 over old 32'hAAAAAAAA → ack rdata=0. A following read returns 32'hAA22AA44.
- Backpressure: hold resp_ready_i=0 for 5 cycles → resp_valid_o and rdata are stable, req_ready_o=0 throughout, and a request presented meanwhile is not accepted. Release → handshake, then req_ready_o=1 the next cycle.
- Errors:
  - read 0x7FFFFFFC → err=1, rdata=0
  - read BASE+4*DEPTH_WORDS → err=1
  - write 0x80000002 → err=1, and the target word is unchanged on readback.
- Reset mid-WAIT: accept a write with LATENCY=4, pull rst_ni low 2 cycles later → outputs return to reset values at once, no response is issued, and readback shows old data.
- LATENCY=1 sweep: 8 back-to-back reads with resp_ready_i=1 → each response arrives 1 cycle after its accept, with a 2-cycle period between accepts.
